frame_receiver: RTL
===================

// Module: frame_receiver
// PURPOSE
//  Upstream stage of the cube display controller. Accepts pixel bytes from the host
//  over an asynchronous byte-wide strobe bus on the GPIO header and packs them into
//  24-bit RGB words. Writes each frame into the back bank of a double-buffered frame
//  RAM; the display controller reads the front bank through a registered read port.
//  Banks swap only at the display's end-of-refresh, so a partly received frame is never shown.
// PARAMETERS
//  ADDR_W          12    word-address width per bank
//  NUM_WORDS       4096  words per frame (16x16x16 LEDs); must be <= 2**ADDR_W
//  BYTES_PER_WORD  3     bytes per word; DATA_W = 8*BYTES_PER_WORD; first byte is MSB
// PORTS
//  clk               in   1       system clock (50 MHz)
//  reset             in   1       one clock clk; reset is synchronous and active-high
//  host_data         in   8       async byte bus; stable while host_strobe is high
//  host_strobe       in   1       async; each rising edge presents one byte
//  host_frame_start  in   1       async; rising edge begins a frame at word 0
//  disp_frame_done   in   1       1-cycle pulse from the display controller at end of refresh
//  rd_addr           in   ADDR_W  display read address (front bank)
//  rd_data           out  DATA_W  front-bank word, registered
//  host_busy         out  1       high while a complete frame awaits a swap
//  front_bank        out  1       bank currently displayed
//  frame_count       out  8       count of completed swaps; wraps 255->0
//  overrun_err       out  1       sticky: byte arrived while busy
//  short_frame_err   out  1       sticky: frame_start arrived mid-frame
// BEHAVIOUR
//  Reset: outputs 0; state IDLE; wr_addr=0; byte_idx=0.
//   Strobe/frame_start sync flops reset to 1, so a line held high through reset makes no edge.
//  Sync: 2-flop synchronizer plus an edge register per control line.
//   host_data is captured from a 2-flop copy when the strobe edge is detected.
//   Edge detection happens 3 clk after the pin edge. Host holds each level for >= 4 clk.
//  FSM:
//   IDLE: frame_start edge -> RECV with wr_addr=0, byte_idx=0. Strobe edges are ignored.
//   RECV: each strobe edge shifts the byte into the word assembler and increments byte_idx.
//    On the BYTES_PER_WORD-th byte, the next cycle writes the word to the back bank at
//    wr_addr, then wr_addr++ and byte_idx=0.
//    The write at wr_addr=NUM_WORDS-1 moves the FSM to PENDING; host_busy=1 in the same cycle.
//    A frame_start edge in RECV restarts at word 0 (byte_idx=0) and sets short_frame_err.
//    Words already written stay in the back bank.
//   PENDING: disp_frame_done toggles front_bank, increments frame_count,
//    clears host_busy, and returns to IDLE.
//    A strobe edge in PENDING drops the byte and sets overrun_err.
//    A frame_start edge is ignored.
//  Simultaneous events:
//   frame_start and strobe edges in the same cycle: frame_start wins and the byte is dropped.
//   disp_frame_done while not PENDING: no effect.
//   Last-word write and disp_frame_done in the same cycle: enter PENDING;
//    the swap waits for the next done pulse.
//  Read port: rd_data <= mem[{front_bank, rd_addr}], 1-cycle latency.
//   A read issued in the same cycle as the swapping disp_frame_done returns the old bank.
//   Reads from the next cycle use the new bank.
//   rd_addr >= NUM_WORDS returns undefined data; no error flag.
//  RAM: 2*2**ADDR_W x DATA_W, simple dual-port inferred (one write port, one read port), no reset.
//   The writer only touches the back bank, so read and write never address the same word.
//  Reset mid-frame: partial frame discarded (contents kept, not shown); front_bank returns to 0.
//  Errors clear only on reset.
// TESTING
//  1. Reset, frame_start, 12288 bytes (word k = 0xk*k pattern), done pulse:
//     host_busy rises on the last write and falls the cycle after done;
//     front_bank=1, frame_count=1, rd_data(addr 5) = packed bytes 15..17 one cycle after rd_addr=5.
//  2. Full frame, done held off 100 cycles, then 2 more strobes:
//     overrun_err=1; front bank still readable and unchanged until done.
//  3. frame_start after 7 bytes, then a full frame:
//     short_frame_err=1; word 0 comes from the second frame; swap proceeds normally.
//  4. disp_frame_done in the same cycle as the last-word write:
//     no swap; the next done pulse swaps; a read in the swap cycle returns the old-bank word.
//  5. frame_start and strobe held high through reset release: no frame starts.
//     Run 256 full frames: frame_count wraps to 0 and front_bank=0.
//  6. Assert reset mid-RECV (word 300):
//     all outputs 0 the next cycle; a new frame then loads from word 0.

Source files
------------

// File: rtl/frame_receiver.sv
// Host byte-bus receiver: synchronises the async strobe bus, packs bytes into words
// and fills the back bank of a double-buffered frame RAM that swaps at end of refresh.
module frame_receiver #(
    parameter int ADDR_W         = 12,
    parameter int NUM_WORDS      = 4096,
    parameter int BYTES_PER_WORD = 3,
    localparam int DATA_W        = 8 * BYTES_PER_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        host_data,
    input  logic              host_strobe,
    input  logic              host_frame_start,
    input  logic              disp_frame_done,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              host_busy,
    output logic              front_bank,
    output logic [7:0]        frame_count,
    output logic              overrun_err,
    output logic              short_frame_err
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);

    typedef enum logic [1:0] {IDLE, RECV, PENDING} state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_addr;
    logic [IDX_W-1:0]  byte_idx;
    logic [DATA_W-1:0] shift_reg;
    logic              word_ready;

    logic       strobe_meta, strobe_sync, strobe_prev;
    logic       start_meta, start_sync, start_prev;
    logic [7:0] data_meta, data_sync;
    logic       strobe_edge, start_edge, mem_we;

    logic [DATA_W-1:0] mem [2**(ADDR_W+1)];

    // Edge flops reset high so a line held high through reset never looks like a new edge.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_meta <= 1'b1;
            strobe_sync <= 1'b1;
            strobe_prev <= 1'b1;
            start_meta  <= 1'b1;
            start_sync  <= 1'b1;
            start_prev  <= 1'b1;
            data_meta   <= 8'd0;
            data_sync   <= 8'd0;
        end else begin
            strobe_meta <= host_strobe;
            strobe_sync <= strobe_meta;
            strobe_prev <= strobe_sync;
            start_meta  <= host_frame_start;
            start_sync  <= start_meta;
            start_prev  <= start_sync;
            data_meta   <= host_data;
            data_sync   <= data_meta;
        end
    end

    assign strobe_edge = strobe_sync & ~strobe_prev;
    assign start_edge  = start_sync & ~start_prev;
    assign mem_we      = (state == RECV) && word_ready && !start_edge;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            wr_addr         <= '0;
            byte_idx        <= '0;
            shift_reg       <= '0;
            word_ready      <= 1'b0;
            host_busy       <= 1'b0;
            front_bank      <= 1'b0;
            frame_count     <= 8'd0;
            overrun_err     <= 1'b0;
            short_frame_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state      <= RECV;
                        wr_addr    <= '0;
                        byte_idx   <= '0;
                        word_ready <= 1'b0;
                    end
                end
                RECV: begin
                    // A restart drops any byte or word landing in the same cycle.
                    if (start_edge) begin
                        wr_addr         <= '0;
                        byte_idx        <= '0;
                        word_ready      <= 1'b0;
                        short_frame_err <= 1'b1;
                    end else begin
                        if (word_ready) begin
                            word_ready <= 1'b0;
                            wr_addr    <= wr_addr + ADDR_W'(1);
                            if (wr_addr == LAST_ADDR) begin
                                state     <= PENDING;
                                host_busy <= 1'b1;
                                wr_addr   <= '0;
                            end
                        end
                        if (strobe_edge) begin
                            shift_reg <= DATA_W'({shift_reg, data_sync});
                            if (byte_idx == LAST_IDX) begin
                                byte_idx   <= '0;
                                word_ready <= 1'b1;
                            end else begin
                                byte_idx <= byte_idx + IDX_W'(1);
                            end
                        end
                    end
                end
                PENDING: begin
                    if (strobe_edge) overrun_err <= 1'b1;
                    if (disp_frame_done) begin
                        front_bank  <= ~front_bank;
                        frame_count <= frame_count + 8'd1;
                        host_busy   <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the frame RAM has no reset so it maps onto block RAM; only the read register resets.
    always_ff @(posedge clk) begin
        if (mem_we) mem[{~front_bank, wr_addr}] <= shift_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) rd_data <= '0;
        else       rd_data <= mem[{front_bank, rd_addr}];
    end

endmodule
